// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer: fetches 8-bit instructions from an async ROM,
// drives register-file reads, a small ALU, write-back and PC-increment strobes.
module cpu_control_sequencer #(
  parameter logic [7:0] PC_LAST = 8'h06
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic [7:0] pc_in,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  output logic [1:0] read_addr1,
  output logic [1:0] read_addr2,
  output logic       write_enable,
  output logic [1:0] write_addr,
  output logic [7:0] write_data,
  output logic       pc_write_enable,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       halted,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_IMM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t     state;
  logic [7:0] ir;
  logic [7:0] result;
  logic [7:0] fetch_addr;

  logic [8:0] alu_wide;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       last_instr;

  function automatic logic is_hlt(input logic [7:0] b);
    return (b[7:6] == 2'b11) && (b[3:2] == 2'b11);
  endfunction

  function automatic logic is_nop(input logic [7:0] b);
    return (b[7:6] == 2'b11) && (b[3:2] == 2'b00);
  endfunction

  function automatic logic is_ldi(input logic [7:0] b);
    return (b[7:6] == 2'b11) && (b[3:2] == 2'b10);
  endfunction

  // Bit 8 of the 9-bit difference doubles as the unsigned borrow for SUB.
  always_comb begin
    alu_wide  = 9'd0;
    alu_out   = 8'd0;
    alu_carry = 1'b0;
    case (ir[7:6])
      2'b00: begin
        alu_wide  = {1'b0, read_data1} + {1'b0, read_data2};
        alu_out   = alu_wide[7:0];
        alu_carry = alu_wide[8];
      end
      2'b01: begin
        alu_wide  = {1'b0, read_data1} - {1'b0, read_data2};
        alu_out   = alu_wide[7:0];
        alu_carry = alu_wide[8];
      end
      2'b10:   alu_out = read_data1 & read_data2;
      default: alu_out = read_data2;
    endcase
  end

  assign last_instr = (fetch_addr == PC_LAST);

  assign read_addr1 = ir[3:2];
  assign read_addr2 = ir[1:0];
  assign write_addr = ir[5:4];
  assign write_data = result;
  assign halted     = (state == S_HALT);
  assign busy       = (state != S_IDLE) && (state != S_HALT);

  // Strobes are registered: each is set on the transition into the cycle
  // in which it must be visible, so they come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      ir              <= 8'd0;
      result          <= 8'd0;
      fetch_addr      <= 8'd0;
      zero_flag       <= 1'b0;
      carry_flag      <= 1'b0;
      write_enable    <= 1'b0;
      pc_write_enable <= 1'b0;
    end else begin
      write_enable    <= 1'b0;
      pc_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          ir              <= instr;
          fetch_addr      <= pc_in;
          pc_write_enable <= !is_hlt(instr);
          state           <= S_DECODE;
        end
        S_DECODE: begin
          if (is_hlt(ir)) begin
            state <= S_HALT;
          end else if (is_nop(ir)) begin
            state <= last_instr ? S_HALT : S_FETCH;
          end else if (is_ldi(ir)) begin
            pc_write_enable <= 1'b1;
            state           <= S_IMM;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          result       <= alu_out;
          zero_flag    <= (alu_out == 8'd0);
          carry_flag   <= alu_carry;
          write_enable <= 1'b1;
          state        <= S_WRITEBACK;
        end
        // PC has already advanced past the opcode, so instr is the immediate.
        S_IMM: begin
          result       <= instr;
          zero_flag    <= (instr == 8'd0);
          write_enable <= 1'b1;
          state        <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          state <= last_instr ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: ROM + register file environment and an
// instruction-level interpreter as reference, directed and random programs.
module tb_cpu_control_sequencer;
  localparam logic [7:0] PC_LAST = 8'h06;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr, pc_in, read_data1, read_data2;
  logic [1:0] read_addr1, read_addr2, write_addr;
  logic       write_enable, pc_write_enable, zero_flag, carry_flag, halted, busy;
  logic [7:0] write_data;

  always #5 clk = ~clk;

  cpu_control_sequencer #(.PC_LAST(PC_LAST)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .pc_in(pc_in),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .pc_write_enable(pc_write_enable), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .halted(halted), .busy(busy)
  );

  // Environment: program ROM, register file and PC register.
  logic [7:0] rom [256];
  logic [7:0] preload [4];
  logic [7:0] regs [4];
  logic [7:0] pc;
  logic       load_req = 1'b0;
  int         strobe_cnt;
  int         both_cnt;
  logic [9:0] wq [$];

  assign instr      = rom[pc];
  assign pc_in      = pc;
  assign read_data1 = regs[read_addr1];
  assign read_data2 = regs[read_addr2];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4; i++) regs[i] <= preload[i];
      pc         <= 8'd0;
      strobe_cnt <= 0;
      both_cnt   <= 0;
      wq.delete();
    end else if (reset_n) begin
      if (write_enable) begin
        regs[write_addr] <= write_data;
        wq.push_back({write_addr, write_data});
      end
      if (pc_write_enable) begin
        pc         <= pc + 8'd1;
        strobe_cnt <= strobe_cnt + 1;
      end
      if (write_enable && pc_write_enable) both_cnt <= both_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int meas_cycles;
  int prog_id = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the program one instruction at a time.
  logic [7:0] m_regs [4];
  logic [9:0] m_wq [$];
  logic       m_z, m_c;
  int         m_strobes, m_cycles;
  logic [7:0] m_pc;

  task automatic model_run();
    logic [7:0] p, fa, ir, v, nx;
    int a, b, s, guard;
    bit done;
    for (int i = 0; i < 4; i++) m_regs[i] = preload[i];
    m_wq.delete();
    m_z = 1'b0; m_c = 1'b0; m_strobes = 0; m_cycles = 0;
    p = 8'd0; done = 1'b0; guard = 0;
    while (!done && guard < 300) begin
      guard++;
      fa = p;
      ir = rom[p];
      a  = int'(m_regs[ir[3:2]]);
      b  = int'(m_regs[ir[1:0]]);
      if (ir[7:6] == 2'b11 && ir[3:2] == 2'b11) begin
        m_cycles += 2;
        done = 1'b1;
      end else if (ir[7:6] == 2'b11 && ir[3:2] == 2'b00) begin
        p = p + 8'd1;
        m_strobes += 1;
        m_cycles += 2;
        done = (fa == PC_LAST);
      end else begin
        if (ir[7:6] == 2'b11 && ir[3:2] == 2'b10) begin
          nx = fa + 8'd1;
          v  = rom[nx];
          p  = fa + 8'd2;
          m_strobes += 2;
        end else begin
          case (ir[7:6])
            2'b00: begin s = a + b; v = 8'(s % 256); m_c = (s > 255); end
            2'b01: begin s = a - b + 256; v = 8'(s % 256); m_c = (a < b); end
            2'b10: begin v = 8'(a & b); m_c = 1'b0; end
            default: begin v = 8'(b); m_c = 1'b0; end
          endcase
          p = p + 8'd1;
          m_strobes += 1;
        end
        m_z = (v == 8'd0);
        m_regs[ir[5:4]] = v;
        m_wq.push_back({ir[5:4], v});
        m_cycles += 4;
        done = (fa == PC_LAST);
      end
    end
    m_pc = p;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
  endtask

  task automatic reset_and_load();
    reset_n  = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic run_prog();
    int n;
    int nw;
    reset_and_load();
    model_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!halted && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    meas_cycles = n;
    prog_id++;
    $display("prog %0d: cycles=%0d writes=%0d strobes=%0d z=%0b c=%0b", prog_id, n,
             wq.size(), strobe_cnt, zero_flag, carry_flag);
    chk("cycles", meas_cycles, m_cycles);
    chk("halted", halted, 1'b1);
    chk("busy_halt", busy, 1'b0);
    chk("write_count", wq.size(), m_wq.size());
    nw = (wq.size() < m_wq.size()) ? wq.size() : m_wq.size();
    for (int i = 0; i < nw; i++) chk($sformatf("write%0d", i), wq[i], m_wq[i]);
    chk("zero_flag", zero_flag, m_z);
    chk("carry_flag", carry_flag, m_c);
    chk("pc_strobes", strobe_cnt, m_strobes);
    chk("strobe_overlap", both_cnt, 0);
    chk("final_pc", pc, m_pc);
    for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), regs[i], m_regs[i]);
  endtask

  initial begin
    int sc, wc;
    for (int i = 0; i < 4; i++) preload[i] = 8'd0;
    clear_rom();

    // Reset asserted while an ADD is in EXECUTE.
    rom[0] = 8'h36; rom[1] = 8'hFF;
    preload[1] = 8'h10; preload[2] = 8'h20;
    reset_and_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_busy_exec", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t1_reset_outputs", {read_addr1, read_addr2, write_enable, write_addr, write_data,
        pc_write_enable, zero_flag, carry_flag, halted, busy}, 24'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t1_no_write", wq.size(), 0);
    chk("t1_idle", {busy, halted}, 2'b00);

    // LDI R1,05; LDI R2,FB; ADD R3,R1,R2; HLT.
    clear_rom();
    rom[0] = 8'hD8; rom[1] = 8'h05; rom[2] = 8'hE8; rom[3] = 8'hFB;
    rom[4] = 8'h36; rom[5] = 8'hFF;
    for (int i = 0; i < 4; i++) preload[i] = 8'd0;
    run_prog();
    chk("t2_cycles14", meas_cycles, 14);
    chk("t2_strobes5", strobe_cnt, 5);
    chk("t2_r3", regs[3], 8'h00);
    chk("t2_flags", {zero_flag, carry_flag}, 2'b11);

    // SUB R0,R1,R2 with R1=03, R2=05.
    clear_rom();
    rom[0] = 8'h46;
    preload[1] = 8'h03; preload[2] = 8'h05;
    run_prog();
    chk("t3_r0", regs[0], 8'hFE);
    chk("t3_cycles", meas_cycles, 6);

    // All NOP up to and including PC_LAST.
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 8'hC0;
    run_prog();
    chk("t4_strobes7", strobe_cnt, 7);
    chk("t4_no_writes", wq.size(), 0);

    // MOV R0,R3; AND R1,R0,R2.
    clear_rom();
    rom[0] = 8'hC7; rom[1] = 8'h92;
    preload[0] = 8'h00; preload[1] = 8'h77; preload[2] = 8'h5A; preload[3] = 8'hA5;
    run_prog();
    chk("t5_r0", regs[0], 8'hA5);
    chk("t5_r1", regs[1], 8'h00);
    chk("t5_flags", {zero_flag, carry_flag}, 2'b10);

    // Start toggling while halted must be ignored.
    sc = strobe_cnt;
    wc = wq.size();
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t6_still_halted", halted, 1'b1);
    chk("t6_no_strobes", strobe_cnt, sc);
    chk("t6_no_writes", wq.size(), wc);

    // LDI whose opcode sits at PC_LAST fetches its immediate from PC_LAST+1.
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = 8'hC0;
    rom[6] = 8'hD8; rom[7] = 8'h00;
    preload[1] = 8'h33;
    run_prog();
    chk("t7_r1", regs[1], 8'h00);
    chk("t7_pc", pc, 8'h08);

    // Random programs and register contents.
    for (int r = 0; r < 24; r++) begin
      clear_rom();
      for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) preload[i] = 8'($urandom);
      run_prog();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
